// File: rtl/mac_pkg.sv
// Shared types, default widths and the saturating add used by the column accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } accum_state_t;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int RESULT_WIDTH_DEF = 3 * DATA_WIDTH_DEF;
    localparam int ACC_WIDTH_DEF    = DATA_WIDTH_DEF + 16;

    // Operands arrive sign-extended to 64 bits from a w-bit accumulator; overflow is
    // judged on bit w-1 and the result is clamped into the signed w-bit range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        s     = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if ((a[w-1] == b[w-1]) && (s[w-1] != a[w-1])) begin
            return a[w-1] ? min_v : max_v;
        end
        return s;
    endfunction

endpackage

// File: rtl/accum_adder.sv
// Combinational sign-extend and add of a column partial sum onto the accumulator base.
// MAC_COLUMN_ACCUM_SAT_EN selects a clamping adder with a clamp indication.
module accum_adder
    import mac_pkg::*;
#(
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0]    base,
    input  logic signed [RESULT_WIDTH-1:0] psum,
    output logic signed [ACC_WIDTH-1:0]    sum
`ifdef MAC_COLUMN_ACCUM_SAT_EN
    ,
    output logic                           clamp
`endif
);

    logic signed [ACC_WIDTH-1:0] psum_ext;

    assign psum_ext = ACC_WIDTH'(psum);

`ifdef MAC_COLUMN_ACCUM_SAT_EN
    logic signed [63:0]          sat_full;
    logic signed [ACC_WIDTH-1:0] wrap_sum;

    assign sat_full = sat_add(64'(base), 64'(psum_ext), ACC_WIDTH);
    assign wrap_sum = base + psum_ext;
    assign sum      = sat_full[ACC_WIDTH-1:0];
    // A clamp is exactly the case where the saturated result departs from the wrapped one.
    assign clamp    = (sum != wrap_sum);
`else
    assign sum = base + psum_ext;
`endif

endmodule

// File: rtl/mac_column_accum.sv
// Accumulates shifted column partial sums of one weight group and presents the dot product
// over valid/ready. Optional saturation and sat_flag port under MAC_COLUMN_ACCUM_SAT_EN.
module mac_column_accum
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 3 * DATA_WIDTH,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int MAX_COLUMNS  = DATA_WIDTH,
    parameter int CNT_WIDTH    = $clog2(MAX_COLUMNS) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [RESULT_WIDTH-1:0] in_psum,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic                           load_accum,
    input  logic signed [ACC_WIDTH-1:0]    accum_prev,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    out_accum,
    output logic [CNT_WIDTH-1:0]           col_count,
    output logic                           overrun
`ifdef MAC_COLUMN_ACCUM_SAT_EN
    ,
    output logic                           sat_flag
`endif
);

    accum_state_t                state;
    accum_state_t                state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        in_xfer;
    logic                        out_xfer;
    logic                        start;
    logic                        cont;
    logic                        take;
    logic                        drop;
    logic                        close_grp;
    logic [CNT_WIDTH-1:0]        cnt_next;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // in_ready in HOLD implies out_ready, so any start taken there overlaps the output transfer.
    assign start     = in_xfer & in_first;
    assign cont      = in_xfer & ~in_first & (state == ACCUM);
    assign take      = start | cont;
    assign drop      = in_xfer & ~take;
    assign cnt_next  = start ? CNT_WIDTH'(1) : col_count + CNT_WIDTH'(1);
    assign close_grp = take & (in_last | (cnt_next == CNT_WIDTH'(MAX_COLUMNS)));

    assign base = in_first ? (load_accum ? accum_prev : '0) : acc;

`ifdef MAC_COLUMN_ACCUM_SAT_EN
    logic clamp;

    accum_adder #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_adder (
        .base (base),
        .psum (in_psum),
        .sum  (sum),
        .clamp(clamp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (take && clamp) begin
            sat_flag <= 1'b1;
        end
    end
`else
    accum_adder #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_adder (
        .base(base),
        .psum(in_psum),
        .sum (sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (take) begin
            state_next = close_grp ? HOLD : ACCUM;
        end else if ((state == HOLD) && out_xfer) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state != HOLD) || out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            out_accum <= '0;
            col_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (take) begin
                acc       <= sum;
                col_count <= cnt_next;
            end else if ((state == HOLD) && out_xfer) begin
                col_count <= '0;
            end
            if (close_grp) begin
                out_accum <= sum;
            end
            // Sticky: a stray non-first column or a group forced shut by the column limit.
            if (drop || (close_grp && !in_last)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_column_accum.sv
// Directed bench for mac_column_accum; define MAC_COLUMN_ACCUM_SAT_EN to cover saturation.
module tb_mac_column_accum;

    localparam int DW  = 8;
    localparam int RW  = 3 * DW;
    localparam int AW  = DW + 16;
    localparam int MC  = DW;
    localparam int CW  = $clog2(MC) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [RW-1:0] in_psum;
    logic                 in_first;
    logic                 in_last;
    logic                 load_accum;
    logic signed [AW-1:0] accum_prev;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_accum;
    logic [CW-1:0]        col_count;
    logic                 overrun;
`ifdef MAC_COLUMN_ACCUM_SAT_EN
    logic                 sat_flag;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_column_accum #(
        .DATA_WIDTH  (DW),
        .RESULT_WIDTH(RW),
        .ACC_WIDTH   (AW),
        .MAX_COLUMNS (MC),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .in_first  (in_first),
        .in_last   (in_last),
        .load_accum(load_accum),
        .accum_prev(accum_prev),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_accum (out_accum),
        .col_count (col_count),
        .overrun   (overrun)
`ifdef MAC_COLUMN_ACCUM_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [RW-1:0] p, input logic f, input logic l);
        in_valid = 1'b1;
        in_psum  = p;
        in_first = f;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic signed [RW-1:0] col_vals [8];

    initial begin
        col_vals = '{24'sd1, 24'sd2, 24'sd4, 24'sd8, 24'sd16, 24'sd32, 24'sd64, -24'sd128};
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_psum    = '0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        load_accum = 1'b0;
        accum_prev = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_col_count", 64'(col_count), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_accum", out_accum, 0);
        reset = 1'b0;
        idle_cycle();

        // Eight-column group: 1+2+...+64-128 = -1
        for (int i = 0; i < 8; i++) begin
            send(col_vals[i], i == 0, i == 7);
            if (i == 6) begin
                chk("g8_count7", 64'(col_count), 7);
                chk("g8_not_valid_yet", 64'(out_valid), 0);
            end
        end
        chk("g8_out_valid", 64'(out_valid), 1);
        chk("g8_out_accum", out_accum, -1);
        chk("g8_count8", 64'(col_count), 8);
        idle_cycle();
        chk("g8_valid_drop", 64'(out_valid), 0);
        chk("g8_count_clr", 64'(col_count), 0);

        // Seeded single column: 1000 - 24
        load_accum = 1'b1;
        accum_prev = 24'sd1000;
        send(-24'sd24, 1'b1, 1'b1);
        load_accum = 1'b0;
        chk("seed_valid", 64'(out_valid), 1);
        chk("seed_accum", out_accum, 976);
        chk("seed_count", 64'(col_count), 1);
        idle_cycle();

        // Back-pressure then overlapped output/input transfer
        out_ready = 1'b0;
        send(24'sd5, 1'b1, 1'b0);
        send(24'sd6, 1'b0, 1'b1);
        chk("bp_accum", out_accum, 11);
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            chk("bp_hold_valid", 64'(out_valid), 1);
            chk("bp_hold_accum", out_accum, 11);
            chk("bp_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(24'sd7, 1'b1, 1'b0);
        chk("b2b_valid_clr", 64'(out_valid), 0);
        chk("b2b_count", 64'(col_count), 1);
        send(24'sd3, 1'b0, 1'b1);
        chk("b2b_valid", 64'(out_valid), 1);
        chk("b2b_accum", out_accum, 10);
        chk("b2b_no_overrun", 64'(overrun), 0);
        idle_cycle();

        // Forced close at MAX_COLUMNS without in_last
        for (int i = 0; i < 8; i++) begin
            send(24'sd1, i == 0, 1'b0);
            if (i == 6) chk("force_open", 64'(out_valid), 0);
        end
        chk("force_valid", 64'(out_valid), 1);
        chk("force_accum", out_accum, 8);
        chk("force_overrun", 64'(overrun), 1);
        idle_cycle();

        // Reset mid-group discards the partial sum
        for (int i = 0; i < 3; i++) send(24'sd100, i == 0, 1'b0);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        chk("abort_valid", 64'(out_valid), 0);
        chk("abort_count", 64'(col_count), 0);
        chk("abort_overrun", 64'(overrun), 0);
        send(24'sd5, 1'b1, 1'b0);
        send(24'sd5, 1'b0, 1'b1);
        chk("abort_next_accum", out_accum, 10);
        idle_cycle();

        // Top-of-range: (2^23-10) + 100
        load_accum = 1'b1;
        accum_prev = 24'sd8388598;
        send(24'sd100, 1'b1, 1'b1);
        load_accum = 1'b0;
`ifdef MAC_COLUMN_ACCUM_SAT_EN
        chk("sat_accum", out_accum, 8388607);
        chk("sat_flag", 64'(sat_flag), 1);
`else
        chk("wrap_accum", out_accum, -8388518);
`endif
        idle_cycle();

        // Non-first column in IDLE is dropped and flags overrun
        send(24'sd50, 1'b0, 1'b0);
        chk("drop_valid", 64'(out_valid), 0);
        chk("drop_count", 64'(col_count), 0);
        chk("drop_overrun", 64'(overrun), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
